// File: rtl/aes_ctr_reg_ctrl_if.sv
// Slice-wise handshake between the CTR counter register and its incrementer.
// Signal suffixes are from the counter register's point of view.
interface aes_ctr_reg_ctrl_if #(
    parameter int unsigned CtrWidth  = 128,
    parameter int unsigned SliceSize = 16
);
    localparam int unsigned NumSlices     = CtrWidth / SliceSize;
    localparam int unsigned SliceIdxWidth = $clog2(NumSlices);

    logic                     incr_o;
    logic                     ready_i;
    logic [SliceIdxWidth-1:0] ctr_slice_idx_i;
    logic [SliceSize-1:0]     ctr_slice_o;
    logic [SliceSize-1:0]     ctr_slice_i;
    logic                     ctr_we_i;
    logic                     alert_i;

    // Incrementer side
    modport master (
        input  incr_o, ctr_slice_o,
        output ready_i, ctr_slice_idx_i, ctr_slice_i, ctr_we_i, alert_i
    );

    // Counter register side
    modport slave (
        output incr_o, ctr_slice_o,
        input  ready_i, ctr_slice_idx_i, ctr_slice_i, ctr_we_i, alert_i
    );
endinterface

// File: rtl/aes_ctr_reg_ctrl.sv
// CTR-mode counter register: launches slice-wise increments, applies the
// incrementer's write-backs and polices the slice protocol.
module aes_ctr_reg_ctrl #(
    parameter int unsigned CtrWidth  = 128,
    parameter int unsigned SliceSize = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                iv_load_i,
    input  logic [CtrWidth-1:0] iv_i,
    input  logic                next_req_i,
    output logic                next_ack_o,
    output logic [CtrWidth-1:0] ctr_o,
    output logic                busy_o,
    output logic                alert_o,
    aes_ctr_reg_ctrl_if.slave   inc_if
);
    localparam int unsigned NumSlices     = CtrWidth / SliceSize;
    localparam int unsigned SliceIdxWidth = $clog2(NumSlices);
    localparam int unsigned CntWidth      = SliceIdxWidth + 1;
    localparam int unsigned BaseWidth     = $clog2(CtrWidth);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(NumSlices);

    // Sparse one-hot encoding; anything else is treated as a fault
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        WAIT  = 3'b010,
        ERROR = 3'b100
    } state_e;

    state_e                state_q;
    logic [CtrWidth-1:0]   ctr_q;
    logic [CntWidth-1:0]   wr_cnt_q;
    logic                  first_q;
    logic [BaseWidth-1:0]  slice_base;

    logic err_c, load_c, incr_c, wr_c, ack_c;

    assign slice_base         = BaseWidth'(inc_if.ctr_slice_idx_i) * BaseWidth'(SliceSize);
    assign inc_if.ctr_slice_o = ctr_q[slice_base +: SliceSize];

    // Decode the current cycle's action; faults override everything else
    always_comb begin
        err_c  = 1'b0;
        load_c = 1'b0;
        incr_c = 1'b0;
        wr_c   = 1'b0;
        ack_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (inc_if.ctr_we_i) begin
                    err_c = 1'b1;
                end else if (iv_load_i) begin
                    load_c = 1'b1;
                end else if (next_req_i && inc_if.ready_i) begin
                    incr_c = 1'b1;
                end
            end
            WAIT: begin
                if (inc_if.ctr_we_i &&
                    ((inc_if.ctr_slice_idx_i != wr_cnt_q[SliceIdxWidth-1:0]) ||
                     (wr_cnt_q == CntFull))) begin
                    err_c = 1'b1;
                end else if (inc_if.ready_i && !first_q && (wr_cnt_q != CntFull)) begin
                    err_c = 1'b1;
                end else begin
                    wr_c  = inc_if.ctr_we_i;
                    ack_c = inc_if.ready_i && (wr_cnt_q == CntFull);
                end
            end
            ERROR: begin
            end
            default: err_c = 1'b1;
        endcase
        if (inc_if.alert_i) begin
            err_c = 1'b1;
        end
        if (err_c) begin
            load_c = 1'b0;
            incr_c = 1'b0;
            wr_c   = 1'b0;
            ack_c  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ctr_q    <= '0;
            wr_cnt_q <= '0;
            first_q  <= 1'b0;
        end else if (err_c) begin
            state_q <= ERROR;
        end else begin
            first_q <= 1'b0;
            if (load_c) begin
                ctr_q <= iv_i;
            end
            if (incr_c) begin
                state_q  <= WAIT;
                wr_cnt_q <= '0;
                first_q  <= 1'b1;
            end
            if (wr_c) begin
                ctr_q[slice_base +: SliceSize] <= inc_if.ctr_slice_i;
                wr_cnt_q                       <= wr_cnt_q + CntWidth'(1);
            end
            if (ack_c) begin
                state_q <= IDLE;
            end
        end
    end

    assign inc_if.incr_o = incr_c;
    assign next_ack_o    = ack_c;
    assign ctr_o         = ctr_q;
    assign busy_o        = (state_q == WAIT);
    assign alert_o       = (state_q == ERROR);
endmodule

// File: tb/tb_aes_ctr_reg_ctrl.sv
// Bench for aes_ctr_reg_ctrl: drives a well-behaved slice incrementer and
// checks final counter values against plain 128-bit addition.
module tb_aes_ctr_reg_ctrl;
    localparam int unsigned CtrWidth  = 128;
    localparam int unsigned SliceSize = 16;
    localparam int unsigned NumSlices = 8;

    logic                clk_i;
    logic                rst_ni;
    logic                iv_load_i;
    logic [CtrWidth-1:0] iv_i;
    logic                next_req_i;
    logic                next_ack_o;
    logic [CtrWidth-1:0] ctr_o;
    logic                busy_o;
    logic                alert_o;

    int n_tests = 0;
    int n_fail  = 0;

    aes_ctr_reg_ctrl_if #(.CtrWidth(CtrWidth), .SliceSize(SliceSize)) inc_if ();

    aes_ctr_reg_ctrl #(.CtrWidth(CtrWidth), .SliceSize(SliceSize)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .iv_load_i  (iv_load_i),
        .iv_i       (iv_i),
        .next_req_i (next_req_i),
        .next_ack_o (next_ack_o),
        .ctr_o      (ctr_o),
        .busy_o     (busy_o),
        .alert_o    (alert_o),
        .inc_if     (inc_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic drive_idle();
        iv_load_i              = 1'b0;
        next_req_i             = 1'b0;
        inc_if.ready_i         = 1'b1;
        inc_if.ctr_we_i        = 1'b0;
        inc_if.ctr_slice_idx_i = '0;
        inc_if.ctr_slice_i     = '0;
        inc_if.alert_i         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        drive_idle();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic load_iv(input logic [CtrWidth-1:0] v);
        @(negedge clk_i);
        drive_idle();
        iv_load_i = 1'b1;
        iv_i      = v;
    endtask

    function automatic logic [CtrWidth-1:0] rand_ctr();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Request cycle T, slice writes T+1..T+8, ack expected at T+9
    task automatic run_incr(input string name, input logic [CtrWidth-1:0] exp,
                            input bit drop_req, input bit load_wait, input bit tail);
        logic [SliceSize:0] sum;
        logic               carry;
        @(negedge clk_i);
        iv_load_i       = 1'b0;
        next_req_i      = 1'b1;
        inc_if.ready_i  = 1'b1;
        inc_if.ctr_we_i = 1'b0;
        #1;
        n_tests++;
        if (inc_if.incr_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: incr_o=%b busy_o=%b, want 1 0", name, inc_if.incr_o, busy_o);
        end
        carry = 1'b1;
        for (int k = 0; k < NumSlices; k++) begin
            @(negedge clk_i);
            inc_if.ready_i         = (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            inc_if.ctr_we_i        = 1'b1;
            inc_if.ctr_slice_idx_i = 3'(k);
            if (drop_req && k == 3) next_req_i = 1'b0;
            if (load_wait && k == 2) begin
                iv_load_i = 1'b1;
                iv_i      = rand_ctr();
            end else begin
                iv_load_i = 1'b0;
            end
            #1;
            sum                = 17'(inc_if.ctr_slice_o) + 17'(carry);
            inc_if.ctr_slice_i = sum[SliceSize-1:0];
            carry              = sum[SliceSize];
            #1;
            n_tests++;
            if (busy_o !== 1'b1 || next_ack_o !== 1'b0 || inc_if.incr_o !== 1'b0 || alert_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s wait[%0d]: busy=%b ack=%b incr=%b alert=%b, want 1 0 0 0",
                         name, k, busy_o, next_ack_o, inc_if.incr_o, alert_o);
            end
        end
        @(negedge clk_i);
        iv_load_i       = 1'b0;
        inc_if.ctr_we_i = 1'b0;
        inc_if.ready_i  = 1'b1;
        #1;
        n_tests++;
        if (next_ack_o !== 1'b1 || busy_o !== 1'b1 || ctr_o !== exp || alert_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ack: ack=%b busy=%b alert=%b ctr=%h, want 1 1 0 %h",
                     name, next_ack_o, busy_o, alert_o, ctr_o, exp);
        end
        if (tail) begin
            @(negedge clk_i);
            next_req_i = 1'b0;
            #1;
            n_tests++;
            if (next_ack_o !== 1'b0 || busy_o !== 1'b0 || ctr_o !== exp) begin
                n_fail++;
                $display("FAIL %s idle: ack=%b busy=%b ctr=%h, want 0 0 %h",
                         name, next_ack_o, busy_o, ctr_o, exp);
            end
        end
    endtask

    // Outputs must stay quiet and ctr frozen once the alert is raised
    task automatic check_terminal(input string name, input logic [CtrWidth-1:0] exp);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            next_req_i             = 1'b1;
            inc_if.ready_i         = 1'($urandom_range(0, 1));
            inc_if.ctr_we_i        = 1'($urandom_range(0, 1));
            inc_if.ctr_slice_idx_i = 3'($urandom_range(0, 7));
            inc_if.ctr_slice_i     = 16'($urandom);
            iv_load_i              = 1'($urandom_range(0, 1));
            iv_i                   = rand_ctr();
            inc_if.alert_i         = 1'b0;
            #1;
            n_tests++;
            if (alert_o !== 1'b1 || next_ack_o !== 1'b0 || inc_if.incr_o !== 1'b0 ||
                busy_o !== 1'b0 || ctr_o !== exp) begin
                n_fail++;
                $display("FAIL %s [%0d]: alert=%b ack=%b incr=%b busy=%b ctr=%h, want 1 0 0 0 %h",
                         name, c, alert_o, next_ack_o, inc_if.incr_o, busy_o, ctr_o, exp);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (ctr_o !== '0 || busy_o !== 1'b0 || next_ack_o !== 1'b0 ||
            inc_if.incr_o !== 1'b0 || alert_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ctr=%h busy=%b ack=%b incr=%b alert=%b, want all 0",
                     ctr_o, busy_o, next_ack_o, inc_if.incr_o, alert_o);
        end
    endtask

    task automatic test_directed();
        logic [CtrWidth-1:0] v;
        load_iv('0);
        run_incr("zero", 128'd1, 1'b0, 1'b0, 1'b1);
        v = 128'h0000_FFFF;
        load_iv(v);
        run_incr("carry", 128'h1_0000, 1'b0, 1'b0, 1'b1);
        v = '1;
        load_iv(v);
        run_incr("wrap", '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [CtrWidth-1:0] v;
        int                  nones;
        for (int i = 0; i < 8; i++) begin
            v     = rand_ctr();
            nones = $urandom_range(0, NumSlices);
            for (int s = 0; s < nones; s++) v[s*SliceSize +: SliceSize] = '1;
            load_iv(v);
            run_incr("random", v + 128'd1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [CtrWidth-1:0] v;
        v = rand_ctr();
        v[SliceSize-1:0] = 16'hFFFE;
        load_iv(v);
        run_incr("b2b_first", v + 128'd1, 1'b0, 1'b0, 1'b0);
        run_incr("b2b_second", v + 128'd2, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_load_priority();
        do_reset();
        @(negedge clk_i);
        iv_load_i      = 1'b1;
        iv_i           = 128'd5;
        next_req_i     = 1'b1;
        inc_if.ready_i = 1'b1;
        #1;
        n_tests++;
        if (inc_if.incr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_prio incr: incr_o=%b, want 0", inc_if.incr_o);
        end
        @(posedge clk_i);
        #1;
        n_tests++;
        if (ctr_o !== 128'd5) begin
            n_fail++;
            $display("FAIL load_prio ctr: ctr=%h, want 5", ctr_o);
        end
        run_incr("load_prio", 128'd6, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_we_in_idle();
        logic [CtrWidth-1:0] v;
        do_reset();
        v = rand_ctr();
        load_iv(v);
        @(negedge clk_i);
        iv_load_i          = 1'b0;
        inc_if.ctr_we_i    = 1'b1;
        inc_if.ctr_slice_i = ~v[SliceSize-1:0];
        check_terminal("we_idle", v);
    endtask

    task automatic test_bad_index();
        logic [CtrWidth-1:0] v;
        do_reset();
        v = rand_ctr();
        load_iv(v);
        @(negedge clk_i);
        iv_load_i      = 1'b0;
        next_req_i     = 1'b1;
        inc_if.ready_i = 1'b1;
        @(negedge clk_i);
        inc_if.ready_i         = 1'b0;
        inc_if.ctr_we_i        = 1'b1;
        inc_if.ctr_slice_idx_i = 3'd2;
        inc_if.ctr_slice_i     = ~v[2*SliceSize +: SliceSize];
        check_terminal("bad_idx", v);
    endtask

    task automatic test_early_ready();
        logic [CtrWidth-1:0] v;
        logic [CtrWidth-1:0] exp;
        logic [SliceSize-1:0] w;
        do_reset();
        v = rand_ctr();
        load_iv(v);
        @(negedge clk_i);
        iv_load_i      = 1'b0;
        next_req_i     = 1'b1;
        inc_if.ready_i = 1'b1;
        @(negedge clk_i);
        w                      = 16'($urandom);
        inc_if.ready_i         = 1'b0;
        inc_if.ctr_we_i        = 1'b1;
        inc_if.ctr_slice_idx_i = 3'd0;
        inc_if.ctr_slice_i     = w;
        @(negedge clk_i);
        inc_if.ready_i         = 1'b1;
        inc_if.ctr_slice_idx_i = 3'd1;
        inc_if.ctr_slice_i     = 16'($urandom);
        exp = v;
        exp[SliceSize-1:0] = w;
        check_terminal("early_ready", exp);
    endtask

    task automatic test_alert_in();
        logic [CtrWidth-1:0] v;
        do_reset();
        v = rand_ctr();
        load_iv(v);
        @(negedge clk_i);
        iv_load_i      = 1'b0;
        inc_if.alert_i = 1'b1;
        check_terminal("alert_in", v);
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        load_iv(rand_ctr());
        @(negedge clk_i);
        iv_load_i      = 1'b0;
        next_req_i     = 1'b1;
        inc_if.ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            inc_if.ready_i         = 1'b0;
            inc_if.ctr_we_i        = 1'b1;
            inc_if.ctr_slice_idx_i = 3'(k);
            inc_if.ctr_slice_i     = 16'($urandom);
        end
        @(negedge clk_i);
        drive_idle();
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (ctr_o !== '0 || busy_o !== 1'b0 || next_ack_o !== 1'b0 ||
            inc_if.incr_o !== 1'b0 || alert_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: ctr=%h busy=%b ack=%b incr=%b alert=%b, want all 0",
                     ctr_o, busy_o, next_ack_o, inc_if.incr_o, alert_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_incr("after_reset", 128'd1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_ni = 1'b0;
        iv_i   = '0;
        drive_idle();
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_load_priority();
        test_we_in_idle();
        test_bad_index();
        test_early_ready();
        test_alert_in();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
